// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide single-port data memory, with sub-word loads and read-modify-write stores.
// Optional macro LSU_STATS_EN builds the load/store/error counters; otherwise the stat ports read 0.
module load_store_unit #(
   parameter int MEM_DEPTH = 2**20,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wr_dat,
   output logic              rd_en,
   output logic              wr_en,
   input  logic [31:0]       m_rd_dat,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_errs
);

   typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_CAP, RMW_WR, RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        lane_q, lane_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              req_ready_d, resp_valid_d, resp_err_d, rd_en_d, wr_en_d;
   logic [31:0]       resp_rdata_d, m_wr_dat_d;
   logic [ADDR_W-1:0] m_addr_d;

   logic [ADDR_W-1:0] word_idx;
   logic              align_err, range_err, f3_err, req_err;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       load_ext, merged;

   assign word_idx  = req_addr >> 2;
   assign range_err = word_idx >= ADDR_W'(MEM_DEPTH);
   assign req_err   = align_err | range_err | f3_err;

   always_comb begin
      align_err = 1'b0;
      f3_err    = 1'b0;
      case (req_funct3[1:0])
         2'b01:   align_err = req_addr[0];
         2'b10:   align_err = |req_addr[1:0];
         default: align_err = 1'b0;
      endcase
      case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_err = 1'b0;
         3'b100, 3'b101:         f3_err = req_we;
         default:                f3_err = 1'b1;
      endcase
   end

   // Lane extraction on the load path, lane insertion on the RMW path.
   assign rd_byte = m_rd_dat[{lane_q, 3'b000} +: 8];
   assign rd_half = lane_q[1] ? m_rd_dat[31:16] : m_rd_dat[15:0];

   always_comb begin
      load_ext = m_rd_dat;
      merged   = m_rd_dat;
      case (funct3_q)
         3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_ext = {24'h0, rd_byte};
         3'b101:  load_ext = {16'h0, rd_half};
         default: load_ext = m_rd_dat;
      endcase
      if (funct3_q == 3'b000)
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   // NOTE: every output is a flop; this block only computes next values, and
   // assigns a default to each of them first so no latch can be inferred.
   always_comb begin
      state_d      = state_q;
      funct3_d     = funct3_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready;
      resp_valid_d = resp_valid;
      resp_err_d   = resp_err;
      resp_rdata_d = resp_rdata;
      m_addr_d     = m_addr;
      m_wr_dat_d   = m_wr_dat;
      rd_en_d      = 1'b0;
      wr_en_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               funct3_d    = req_funct3;
               lane_d      = req_addr[1:0];
               wdata_d     = req_wdata[15:0];
               m_addr_d    = word_idx;
               req_ready_d = 1'b0;
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = RESP;
               end else if (!req_we) begin
                  rd_en_d = 1'b1;
                  state_d = LD_RD;
               end else if (req_funct3 == 3'b010) begin
                  wr_en_d    = 1'b1;
                  m_wr_dat_d = req_wdata;
                  state_d    = ST_WR;
               end else begin
                  rd_en_d = 1'b1;
                  state_d = RMW_RD;
               end
            end
         end
         LD_RD:  state_d = LD_CAP;
         LD_CAP: begin
            resp_rdata_d = load_ext;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RMW_RD: state_d = RMW_CAP;
         RMW_CAP: begin
            m_wr_dat_d = merged;
            wr_en_d    = 1'b1;
            state_d    = RMW_WR;
         end
         ST_WR, RMW_WR: begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            req_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         funct3_q   <= '0;
         lane_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         m_addr     <= '0;
         m_wr_dat   <= '0;
         rd_en      <= 1'b0;
         wr_en      <= 1'b0;
      end else begin
         state_q    <= state_d;
         funct3_q   <= funct3_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
         m_addr     <= m_addr_d;
         m_wr_dat   <= m_wr_dat_d;
         rd_en      <= rd_en_d;
         wr_en      <= wr_en_d;
      end
   end

`ifdef LSU_STATS_EN
   logic we_q;
   logic resp_hs;

   assign resp_hs = (state_q == RESP) && resp_ready;

   // Counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q        <= 1'b0;
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else begin
         if (state_q == IDLE && req_valid) we_q <= req_we;
         if (resp_hs) begin
            if (resp_err) begin
               if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
            end else if (we_q) begin
               if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
            end else begin
               if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
            end
         end
      end
   end
`else
   assign stat_loads  = '0;
   assign stat_stores = '0;
   assign stat_errs   = '0;
`endif

endmodule
